dac_wavegen: RTL

Periodic waveform generator that produces the 8-bit sample word for the board's R-2R DAC output pins. It sits directly upstream of the DAC driver and takes single-cycle, already-debounced button event pulses from the push-button stage. A fixed-rate prescaler drives a phase accumulator, and the phase is mapped to sawtooth, triangle, square or sine. The sample word is registered and presented on `dac_bin` together with a one-cycle `sample_stb`.

---
 rtl/dac_wavegen.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dac_wavegen.sv
// Periodic waveform generator: prescaled phase accumulator mapped to an 8-bit R-2R DAC word.
// Define WAVEGEN_SINE_EN to build the quarter-wave sine ROM and enable wave 3 (sine).
module dac_wavegen #(
  parameter int unsigned PHASE_W   = 16,
  parameter int unsigned DIV       = 1024,
  parameter int unsigned STEP_INIT = 256
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               evt_next,
  input  logic               evt_up,
  input  logic               evt_down,
  output logic [7:0]         dac_bin,
  output logic               sample_stb,
  output logic [1:0]         wave,
  output logic [PHASE_W-1:0] step
);

  localparam int unsigned        CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [PHASE_W-1:0] STEP_MAX = {1'b1, {(PHASE_W - 1){1'b0}}};

`ifdef WAVEGEN_SINE_EN
  // round(127 * sin(pi/2 * (i + 0.5) / 64)), i = 0..63
  localparam logic [7:0] SINE_ROM [64] = '{
    8'd2,   8'd5,   8'd8,   8'd11,  8'd14,  8'd17,  8'd20,  8'd23,
    8'd26,  8'd29,  8'd32,  8'd35,  8'd38,  8'd41,  8'd44,  8'd47,
    8'd50,  8'd53,  8'd56,  8'd58,  8'd61,  8'd64,  8'd67,  8'd69,
    8'd72,  8'd74,  8'd77,  8'd79,  8'd82,  8'd84,  8'd86,  8'd89,
    8'd91,  8'd93,  8'd95,  8'd97,  8'd99,  8'd101, 8'd103, 8'd105,
    8'd106, 8'd108, 8'd110, 8'd111, 8'd113, 8'd114, 8'd115, 8'd117,
    8'd118, 8'd119, 8'd120, 8'd121, 8'd122, 8'd123, 8'd124, 8'd124,
    8'd125, 8'd125, 8'd126, 8'd126, 8'd127, 8'd127, 8'd127, 8'd127
  };
  logic [5:0] sine_idx;
  logic [7:0] sine_q;
  logic [7:0] sine_val;
`endif

  logic [CNT_W-1:0]   div_cnt;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_n;
  logic               tick;
  logic [7:0]         p;
  logic [7:0]         tri_t;
  logic [7:0]         tri_val;
  logic [7:0]         sample;
  logic [1:0]         wave_n;
  logic [PHASE_W-1:0] step_n;

  always_comb begin
    tick    = (div_cnt == CNT_LAST);
    phase_n = phase + step;
    p       = phase_n[PHASE_W-1 -: 8];
    tri_t   = {p[6:0], 1'b0};
    tri_val = p[7] ? ~tri_t : tri_t;
  end

`ifdef WAVEGEN_SINE_EN
  always_comb begin
    sine_idx = p[6] ? ~p[5:0] : p[5:0];
    sine_q   = SINE_ROM[sine_idx];
    sine_val = p[7] ? (8'd127 - sine_q) : (8'd128 + sine_q);
  end
`endif

  always_comb begin
    sample = p;
    case (wave)
      2'd0:    sample = p;
      2'd1:    sample = tri_val;
      2'd2:    sample = p[7] ? 8'hFF : 8'h00;
`ifdef WAVEGEN_SINE_EN
      default: sample = sine_val;
`else
      default: sample = tri_val;
`endif
    endcase
  end

  always_comb begin
    wave_n = wave;
    if (evt_next) begin
`ifdef WAVEGEN_SINE_EN
      wave_n = wave + 2'd1;
`else
      wave_n = (wave >= 2'd2) ? 2'd0 : wave + 2'd1;
`endif
    end
  end

  // Simultaneous up and down cancel; both directions saturate.
  always_comb begin
    step_n = step;
    if (evt_up && !evt_down) begin
      step_n = (step > (STEP_MAX >> 1)) ? STEP_MAX : (step << 1);
    end else if (evt_down && !evt_up) begin
      step_n = (step[PHASE_W-1:1] == '0) ? PHASE_W'(1) : (step >> 1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt    <= '0;
      phase      <= '0;
      dac_bin    <= 8'h00;
      sample_stb <= 1'b0;
      wave       <= 2'd0;
      step       <= PHASE_W'(STEP_INIT);
    end else begin
      div_cnt    <= tick ? '0 : div_cnt + CNT_W'(1);
      sample_stb <= tick;
      if (tick) begin
        phase   <= phase_n;
        dac_bin <= sample;
      end
      wave <= wave_n;
      step <= step_n;
    end
  end

endmodule
